seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the shared `seg7` decoder.
- Holds NUM_DIGITS 4-bit digit values plus a decimal-point bit per digit, written by a simple write port.
- Drives the decoder inputs w/x/y/z/dp with one digit at a time and asserts the matching active-low anode.
- Inserts a blanking gap between digits to prevent ghosting, and pulses `frame_tick` once per full scan.

---
 rtl/seg7_scan_ctrl_if.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 110 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Write port bundle for seg7_scan_ctrl: one digit nibble plus decimal point per strobe.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
);
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [3:0]       wr_data;
    logic             wr_dp;

    modport master (output wr_en, wr_addr, wr_data, wr_dp);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_dp);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Each digit slot is REFRESH_DIV
// cycles: BLANK_CYCLES with all anodes off, then the rest with one anode on.
// The decoder nibble is reloaded only when a slot ends, so it never moves
// while an anode is driven.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       wr,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic                  w,
    output logic                  x,
    output logic                  y,
    output logic                  z,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      cur_idx,
    output logic                  frame_tick
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [4:0]            nib_q, nib_d;
    logic                  ft_q, ft_d;
    logic [4:0]            regs_q [NUM_DIGITS];

    // Digit register file: {nibble, dp} per digit; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr.wr_en && (int'(wr.wr_addr) < NUM_DIGITS)) begin
            regs_q[wr.wr_addr] <= {wr.wr_data, wr.wr_dp};
        end
    end

    // Scan state, slot counter, digit index and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            nib_q   <= '0;
            ft_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            nib_q   <= nib_d;
            ft_q    <= ft_d;
        end
    end

    // Next state: open the anode after the blanking gap (enable sampled here
    // only), and at slot end close it, advance the digit and load its contents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        an_d    = an_q;
        nib_d   = nib_q;
        ft_d    = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    if (digit_en[idx_q]) begin
                        an_d = ~(NUM_DIGITS'(1) << idx_q);
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    nib_d   = regs_q[idx_d];
                    ft_d    = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = S_BLANK;
            end
        endcase
    end

    assign {w, x, y, z, dp} = nib_q;
    assign an               = an_q;
    assign cur_idx          = idx_q;
    assign frame_tick       = ft_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed timeline tables for a 4-digit and a
// 3-digit build, plus randomized traffic on the 4-digit build against a
// time-based reference model.
module tb_seg7_scan_ctrl;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int NA = 4;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(NA)) ifa ();
    seg7_scan_ctrl_if #(.NUM_DIGITS(NB)) ifb ();

    logic [NA-1:0] digit_en_a, an_a;
    logic [NB-1:0] digit_en_b, an_b;
    logic wa, xa, ya, za, dpa, ft_a;
    logic wb, xb, yb, zb, dpb, ft_b;
    logic [1:0] idx_a, idx_b;
    logic [4:0] nib_a, nib_b;
    assign nib_a = {wa, xa, ya, za, dpa};
    assign nib_b = {wb, xb, yb, zb, dpb};

    seg7_scan_ctrl #(.NUM_DIGITS(NA), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut_a (
        .clk(clk), .rst(rst), .wr(ifa.slave), .digit_en(digit_en_a),
        .w(wa), .x(xa), .y(ya), .z(za), .dp(dpa),
        .an(an_a), .cur_idx(idx_a), .frame_tick(ft_a)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(NB), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut_b (
        .clk(clk), .rst(rst), .wr(ifb.slave), .digit_en(digit_en_b),
        .w(wb), .x(xb), .y(yb), .z(zb), .dp(dpb),
        .an(an_b), .cur_idx(idx_b), .frame_tick(ft_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model for the 4-digit build: position inside the scan is
    // derived purely from the number of clock edges since reset.
    int         mk;
    int         m_pos, m_s, m_cur;
    logic [4:0] mregs [NA];
    logic [3:0] m_an;
    logic [4:0] m_nib;
    logic [1:0] m_idx;
    logic       m_ft;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mk = 0;
                for (int i = 0; i < NA; i++) mregs[i] = 5'd0;
                m_an = 4'hF; m_nib = 5'd0; m_idx = 2'd0; m_ft = 1'b0;
            end else begin
                m_pos = mk % R;
                m_s   = mk / R;
                m_cur = m_s % NA;
                m_ft  = 1'b0;
                if (m_pos == B - 1)
                    m_an = digit_en_a[m_cur] ? ~(4'b0001 << m_cur) : 4'hF;
                if (m_pos == R - 1) begin
                    m_cur = (m_s + 1) % NA;
                    m_an  = 4'hF;
                    m_nib = mregs[m_cur];
                    m_idx = m_cur[1:0];
                    m_ft  = (m_cur == 0);
                end
                if (ifa.wr_en && int'(ifa.wr_addr) < NA)
                    mregs[ifa.wr_addr] = {ifa.wr_data, ifa.wr_dp};
                mk++;
            end
        end
    end

    bit         mon_on = 1'b0;
    logic [4:0] prev_nib = 5'd0;
    logic       prev_drive = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk($sformatf("model_a k=%0d", mk), {20'd0, an_a, nib_a, idx_a, ft_a},
                    {20'd0, m_an, m_nib, m_idx, m_ft});
                chk("an_single_low", 32'($countones(~an_a) <= 1), 32'd1);
                if (prev_drive && an_a != 4'hF)
                    chk("nib_stable_while_driven", {27'd0, nib_a}, {27'd0, prev_nib});
                prev_nib   = nib_a;
                prev_drive = (an_a != 4'hF);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0] k;
        logic [3:0] an;
        logic [3:0] nib;
        logic       dp;
        logic [1:0] idx;
        logic       ft;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    task automatic adda(input int k, input logic [3:0] an, input logic [3:0] nib,
                        input logic dp, input logic [1:0] idx, input logic ft);
        va.push_back({8'(k), an, nib, dp, idx, ft});
    endtask

    task automatic addb(input int k, input logic [3:0] an, input logic [3:0] nib,
                        input logic dp, input logic [1:0] idx, input logic ft);
        vb.push_back({8'(k), an, nib, dp, idx, ft});
    endtask

    // Directed inputs applied for clock edge j (edge 1 is the first after reset release).
    task automatic set_inputs(input int j);
        ifa.wr_en = 1'b0; ifa.wr_addr = 2'd0; ifa.wr_data = 4'd0; ifa.wr_dp = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_addr = 2'd0; ifb.wr_data = 4'd0; ifb.wr_dp = 1'b0;
        if (j >= 1 && j <= 4) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = 2'(j - 1); ifa.wr_data = 4'(j);
        end else if (j == 5) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = 2'd3; ifa.wr_data = 4'd4; ifa.wr_dp = 1'b1;
        end else if (j == 16) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = 2'd2; ifa.wr_data = 4'hF;
        end
        if (j >= 1 && j <= 3) begin
            ifb.wr_en = 1'b1; ifb.wr_addr = 2'(j - 1); ifb.wr_data = 4'(j + 4);
            ifb.wr_dp = (j == 2);
        end else if (j == 4 || j == 9) begin
            ifb.wr_en = 1'b1; ifb.wr_addr = 2'd3; ifb.wr_data = 4'hF; ifb.wr_dp = 1'b1;
        end
        if (j <= 64)       digit_en_a = 4'b1111;
        else if (j <= 99)  digit_en_a = 4'b0101;
        else if (j <= 115) digit_en_a = 4'b0000;
        else               digit_en_a = 4'b1111;
        digit_en_b = 3'b111;
    endtask

    int ek, ia, ib;

    initial begin
        // 4-digit timeline: k, an, nibble, dp, idx, frame_tick
        adda(1, 4'hF, 4'h0, 0, 0, 0);   adda(2, 4'hE, 4'h0, 0, 0, 0);
        adda(7, 4'hE, 4'h0, 0, 0, 0);   adda(8, 4'hF, 4'h2, 0, 1, 0);
        adda(10, 4'hD, 4'h2, 0, 1, 0);  adda(16, 4'hF, 4'h3, 0, 2, 0);
        adda(18, 4'hB, 4'h3, 0, 2, 0);  adda(24, 4'hF, 4'h4, 1, 3, 0);
        adda(26, 4'h7, 4'h4, 1, 3, 0);  adda(32, 4'hF, 4'h1, 0, 0, 1);
        adda(33, 4'hF, 4'h1, 0, 0, 0);  adda(34, 4'hE, 4'h1, 0, 0, 0);
        adda(48, 4'hF, 4'hF, 0, 2, 0);  adda(50, 4'hB, 4'hF, 0, 2, 0);
        adda(64, 4'hF, 4'h1, 0, 0, 1);  adda(66, 4'hE, 4'h1, 0, 0, 0);
        adda(74, 4'hF, 4'h2, 0, 1, 0);  adda(82, 4'hB, 4'hF, 0, 2, 0);
        adda(90, 4'hF, 4'h4, 1, 3, 0);  adda(96, 4'hF, 4'h1, 0, 0, 1);
        adda(98, 4'hE, 4'h1, 0, 0, 0);  adda(103, 4'hE, 4'h1, 0, 0, 0);
        adda(104, 4'hF, 4'h2, 0, 1, 0); adda(107, 4'hF, 4'h2, 0, 1, 0);
        adda(115, 4'hF, 4'hF, 0, 2, 0); adda(122, 4'h7, 4'h4, 1, 3, 0);
        adda(124, 4'h7, 4'h4, 1, 3, 0);
        // 3-digit timeline (an in low 3 bits)
        addb(1, 4'h7, 4'h0, 0, 0, 0);   addb(8, 4'h7, 4'h6, 1, 1, 0);
        addb(10, 4'h5, 4'h6, 1, 1, 0);  addb(24, 4'h7, 4'h5, 0, 0, 1);
        addb(26, 4'h6, 4'h5, 0, 0, 0);  addb(34, 4'h5, 4'h6, 1, 1, 0);
        addb(42, 4'h3, 4'h7, 0, 2, 0);  addb(48, 4'h7, 4'h5, 0, 0, 1);
        addb(58, 4'h5, 4'h6, 1, 1, 0);  addb(66, 4'h3, 4'h7, 0, 2, 0);

        rst = 1'b1;
        set_inputs(0);
        repeat (3) @(negedge clk);
        chk("reset_a", {20'd0, an_a, nib_a, idx_a, ft_a}, {20'd0, 4'hF, 5'd0, 2'd0, 1'b0});
        chk("reset_b", {21'd0, an_b, nib_b, idx_b, ft_b}, {21'd0, 3'h7, 5'd0, 2'd0, 1'b0});

        mon_on = 1'b1;
        set_inputs(1);
        rst = 1'b0;
        ek = 0; ia = 0; ib = 0;
        while (ek < 124) begin
            @(posedge clk);
            ek++;
            #1;
            while (ia < va.size() && int'(va[ia].k) == ek) begin
                chk($sformatf("table_a k=%0d", ek), {20'd0, an_a, nib_a, idx_a, ft_a},
                    {20'd0, va[ia].an, va[ia].nib, va[ia].dp, va[ia].idx, va[ia].ft});
                ia++;
            end
            while (ib < vb.size() && int'(vb[ib].k) == ek) begin
                chk($sformatf("table_b k=%0d", ek), {20'd0, 1'b0, an_b, nib_b, idx_b, ft_b},
                    {20'd0, vb[ib].an, vb[ib].nib, vb[ib].dp, vb[ib].idx, vb[ib].ft});
                ib++;
            end
            set_inputs(ek + 1);
        end
        chk("table_a_consumed", 32'(ia), 32'(va.size()));
        chk("table_b_consumed", 32'(ib), 32'(vb.size()));

        // Asynchronous reset in the middle of a driven slot.
        #1 rst = 1'b1;
        #1;
        chk("async_reset_a", {20'd0, an_a, nib_a, idx_a, ft_a}, {20'd0, 4'hF, 5'd0, 2'd0, 1'b0});
        chk("async_reset_b", {21'd0, an_b, nib_b, idx_b, ft_b}, {21'd0, 3'h7, 5'd0, 2'd0, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Randomized traffic on the 4-digit build, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            ifa.wr_en   = 1'($urandom_range(0, 3) == 0);
            ifa.wr_addr = 2'($urandom_range(0, 3));
            ifa.wr_data = 4'($urandom);
            ifa.wr_dp   = 1'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en_a = 4'($urandom);
        end

        @(negedge clk);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
